// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM: sequences fetch, decode, execute, memory
// and writeback steps and drives the datapath selects and write strobes.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       branch,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_re,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_sel,
  output logic [3:0] state
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpSltiu = 6'b001011;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] FnJr    = 6'b001000;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StIExec  = 4'd9,
    StIWb    = 4'd10,
    StJump   = 4'd11,
    StJReg   = 4'd12
  } state_e;

  state_e state_q, state_d;

  // Strobes before reset gating.
  logic pc_we_c, branch_c, branch_ne_c, mem_re_c, mem_we_c, ir_we_c, reg_we_c;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StFetch;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        unique case (opcode)
          OpLw, OpSw:     state_d = StMemAdr;
          OpRtype:        state_d = (funct == FnJr) ? StJReg : StExec;
          OpBeq, OpBne:   state_d = StBranch;
          OpAddi, OpAddiu, OpSlti, OpSltiu,
          OpAndi, OpOri, OpXori, OpLui:
                          state_d = StIExec;
          OpJ, OpJal:     state_d = StJump;
          default:        state_d = StFetch;  // unknown opcode acts as NOP
        endcase
      end
      StMemAdr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StIExec:  state_d = StIWb;
      StIWb:    state_d = StFetch;
      StJump:   state_d = StFetch;
      StJReg:   state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Output decode from the current state (mem_ready only qualifies FETCH writes).
  always_comb begin
    pc_we_c     = 1'b0;
    pc_src      = 2'b00;
    branch_c    = 1'b0;
    branch_ne_c = 1'b0;
    iord        = 1'b0;
    mem_re_c    = 1'b0;
    mem_we_c    = 1'b0;
    ir_we_c     = 1'b0;
    reg_we_c    = 1'b0;
    reg_dst     = 2'b00;
    mem_to_reg  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_sel     = 2'b00;
    case (state_q)
      StFetch: begin
        mem_re_c  = 1'b1;
        alu_src_b = 2'b01;
        ir_we_c   = mem_ready;
        pc_we_c   = mem_ready;
      end
      StDecode: alu_src_b = 2'b11;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd: begin
        iord     = 1'b1;
        mem_re_c = 1'b1;
      end
      StMemWb: begin
        reg_we_c   = 1'b1;
        mem_to_reg = 2'b01;
      end
      StMemWr: begin
        iord     = 1'b1;
        mem_we_c = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_sel   = 2'b10;
      end
      StAluWb: begin
        reg_we_c = 1'b1;
        reg_dst  = 2'b01;
      end
      StBranch: begin
        alu_src_a   = 1'b1;
        alu_sel     = 2'b01;
        pc_src      = 2'b01;
        branch_c    = (opcode == OpBeq);
        branch_ne_c = (opcode == OpBne);
      end
      StIExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_sel   = 2'b10;
      end
      StIWb: reg_we_c = 1'b1;
      StJump: begin
        pc_we_c = 1'b1;
        pc_src  = 2'b10;
        if (opcode == OpJal) begin
          reg_we_c   = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
      end
      StJReg: begin
        pc_we_c = 1'b1;
        pc_src  = 2'b11;
      end
      default: ;
    endcase
  end

  // Strobes are suppressed combinationally while reset is held.
  assign pc_we     = pc_we_c & reset_n;
  assign branch    = branch_c & reset_n;
  assign branch_ne = branch_ne_c & reset_n;
  assign mem_re    = mem_re_c & reset_n;
  assign mem_we    = mem_we_c & reset_n;
  assign ir_we     = ir_we_c & reset_n;
  assign reg_we    = reg_we_c & reset_n;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through its state
// sequence and checks the decoded controls against hand-computed values.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_we, branch, branch_ne, iord, mem_re, mem_we, ir_we, reg_we, alu_src_a;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_sel;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  mc_ctrl u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .opcode    (opcode),
    .funct     (funct),
    .mem_ready (mem_ready),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .branch    (branch),
    .branch_ne (branch_ne),
    .iord      (iord),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .ir_we     (ir_we),
    .reg_we    (reg_we),
    .reg_dst   (reg_dst),
    .mem_to_reg(mem_to_reg),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_sel   (alu_sel),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_n = 1'b0; opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
    #3;
    check("rst_state", 8'(state), 8'd0);
    check("rst_mem_re", 8'(mem_re), 8'd0);
    check("rst_pc_we", 8'(pc_we), 8'd0);
    check("rst_ir_we", 8'(ir_we), 8'd0);
    #20 reset_n = 1'b1;
    #1;
    check("rel_state", 8'(state), 8'd0);
    check("rel_mem_re", 8'(mem_re), 8'd1);
    check("fetch_ir_we", 8'(ir_we), 8'd1);
    check("fetch_pc_we", 8'(pc_we), 8'd1);
    check("fetch_src_b", 8'(alu_src_b), 8'd1);

    // R-type ADD: 0,1,6,7,0
    tick();
    check("r_dec", 8'(state), 8'd1);
    check("r_dec_src_b", 8'(alu_src_b), 8'd3);
    check("r_dec_reg_we", 8'(reg_we), 8'd0);
    tick();
    check("r_exec", 8'(state), 8'd6);
    check("r_exec_sel", 8'(alu_sel), 8'd2);
    check("r_exec_src_a", 8'(alu_src_a), 8'd1);
    check("r_exec_reg_we", 8'(reg_we), 8'd0);
    tick();
    check("r_aluwb", 8'(state), 8'd7);
    check("r_aluwb_reg_we", 8'(reg_we), 8'd1);
    check("r_aluwb_dst", 8'(reg_dst), 8'd1);
    tick();
    check("r_done", 8'(state), 8'd0);

    // Async reset in EXEC
    tick(); tick();
    check("ar_exec", 8'(state), 8'd6);
    #1 reset_n = 1'b0;
    #1;
    check("ar_state", 8'(state), 8'd0);
    check("ar_reg_we", 8'(reg_we), 8'd0);
    check("ar_mem_re", 8'(mem_re), 8'd0);
    tick();
    check("ar_hold", 8'(state), 8'd0);
    reset_n = 1'b1;
    #1;
    check("ar_rel_mem_re", 8'(mem_re), 8'd1);

    // LW with two wait cycles in MEMRD: 0,1,2,3,3,3,4,0
    opcode = 6'b100011;
    tick();
    check("lw_dec", 8'(state), 8'd1);
    tick();
    check("lw_adr", 8'(state), 8'd2);
    check("lw_adr_src_b", 8'(alu_src_b), 8'd2);
    mem_ready = 1'b0;
    tick();
    check("lw_rd0", 8'(state), 8'd3);
    check("lw_rd_iord", 8'(iord), 8'd1);
    check("lw_rd_mem_re", 8'(mem_re), 8'd1);
    check("lw_rd_reg_we", 8'(reg_we), 8'd0);
    tick();
    check("lw_rd1", 8'(state), 8'd3);
    tick();
    check("lw_rd2", 8'(state), 8'd3);
    mem_ready = 1'b1;
    tick();
    check("lw_wb", 8'(state), 8'd4);
    check("lw_wb_reg_we", 8'(reg_we), 8'd1);
    check("lw_wb_m2r", 8'(mem_to_reg), 8'd1);
    check("lw_wb_dst", 8'(reg_dst), 8'd0);
    tick();
    check("lw_done", 8'(state), 8'd0);

    // FETCH wait of 3 cycles, then illegal opcode as NOP
    opcode = 6'b111111;
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("fw_state", 8'(state), 8'd0);
      check("fw_ir_we", 8'(ir_we), 8'd0);
      check("fw_pc_we", 8'(pc_we), 8'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("fw_ir_we_go", 8'(ir_we), 8'd1);
    check("fw_pc_we_go", 8'(pc_we), 8'd1);
    tick();
    check("ill_dec", 8'(state), 8'd1);
    check("ill_ir_we", 8'(ir_we), 8'd0);
    check("ill_reg_we", 8'(reg_we), 8'd0);
    check("ill_mem_we", 8'(mem_we), 8'd0);
    tick();
    check("ill_fetch", 8'(state), 8'd0);

    // BNE: 0,1,8,0
    opcode = 6'b000101;
    tick(); tick();
    check("bne_state", 8'(state), 8'd8);
    check("bne_bne", 8'(branch_ne), 8'd1);
    check("bne_beq", 8'(branch), 8'd0);
    check("bne_pc_src", 8'(pc_src), 8'd1);
    check("bne_sel", 8'(alu_sel), 8'd1);
    check("bne_pc_we", 8'(pc_we), 8'd0);
    tick();
    check("bne_done", 8'(state), 8'd0);

    // BEQ
    opcode = 6'b000100;
    tick(); tick();
    check("beq_state", 8'(state), 8'd8);
    check("beq_beq", 8'(branch), 8'd1);
    check("beq_bne", 8'(branch_ne), 8'd0);
    tick();

    // JAL: 0,1,11,0
    opcode = 6'b000011;
    tick(); tick();
    check("jal_state", 8'(state), 8'd11);
    check("jal_pc_we", 8'(pc_we), 8'd1);
    check("jal_pc_src", 8'(pc_src), 8'd2);
    check("jal_reg_we", 8'(reg_we), 8'd1);
    check("jal_dst", 8'(reg_dst), 8'd2);
    check("jal_m2r", 8'(mem_to_reg), 8'd2);
    tick();
    check("jal_done", 8'(state), 8'd0);

    // J: no link write
    opcode = 6'b000010;
    tick(); tick();
    check("j_state", 8'(state), 8'd11);
    check("j_reg_we", 8'(reg_we), 8'd0);
    tick();

    // JR: 0,1,12,0
    opcode = 6'b000000; funct = 6'b001000;
    tick(); tick();
    check("jr_state", 8'(state), 8'd12);
    check("jr_pc_src", 8'(pc_src), 8'd3);
    check("jr_pc_we", 8'(pc_we), 8'd1);
    tick();
    check("jr_done", 8'(state), 8'd0);

    // SW with one wait: 0,1,2,5,5,0
    opcode = 6'b101011;
    tick(); tick();
    check("sw_adr", 8'(state), 8'd2);
    mem_ready = 1'b0;
    tick();
    check("sw_wr", 8'(state), 8'd5);
    check("sw_mem_we", 8'(mem_we), 8'd1);
    check("sw_iord", 8'(iord), 8'd1);
    check("sw_mem_re", 8'(mem_re), 8'd0);
    tick();
    check("sw_wait", 8'(state), 8'd5);
    mem_ready = 1'b1;
    tick();
    check("sw_done", 8'(state), 8'd0);

    // ADDI: 0,1,9,10,0
    opcode = 6'b001000;
    tick(); tick();
    check("addi_exec", 8'(state), 8'd9);
    check("addi_sel", 8'(alu_sel), 8'd2);
    check("addi_src_b", 8'(alu_src_b), 8'd2);
    tick();
    check("addi_wb", 8'(state), 8'd10);
    check("addi_reg_we", 8'(reg_we), 8'd1);
    check("addi_dst", 8'(reg_dst), 8'd0);
    tick();
    check("addi_done", 8'(state), 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
